zuc_ks_xor: RTL and testbench

- Consumer end of the ZUC keystream interface. It accepts the per-word keystream strobe (Z, done, L_out) from the ZUC generator and buffers the words in a small FIFO, because the generator cannot be back-pressured.
- Each keystream word is XORed with a plaintext/ciphertext word taken over a valid/ready input.
- The result leaves on a valid/ready output.
- The block counts words against a programmed length and flags overflow and index errors.

---
 rtl/zuc_pkg.sv | 21 ++
 rtl/zuc_ks_fifo.sv | 63 ++++++
 rtl/zuc_ks_xor.sv | 187 ++++++++++++++++++
 tb/tb_zuc_ks_xor.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zuc_pkg.sv
// Shared definitions for the ZUC keystream consumer: word/length widths,
// controller state encoding and the keystream/data combine helper.
package zuc_pkg;

    localparam int unsigned ZUC_WORD_W = 32;
    localparam int unsigned ZUC_LEN_W  = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } zuc_state_e;

    // Encryption and decryption are the same operation on a stream cipher.
    function automatic logic [ZUC_WORD_W-1:0] ks_xor(
        input logic [ZUC_WORD_W-1:0] data,
        input logic [ZUC_WORD_W-1:0] ks
    );
        return data ^ ks;
    endfunction

endpackage

// File: rtl/zuc_ks_fifo.sv
// Keystream buffer: synchronous FIFO with flush and a combinational head.
// Pointers carry one extra wrap bit so full and empty come straight from them.
module zuc_ks_fifo
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] head_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic          wr_c;
    logic          rd_c;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO still lands when the head is leaving the same cycle.
    assign wr_c = push_i && (!full_o || pop_i);
    assign rd_c = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_c) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_c) rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_c && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/zuc_ks_xor.sv
// ZUC keystream consumer: buffers generator words, XORs them onto a data
// stream and counts against a programmed length. ZUC_IDX_CHECK_EN adds the
// keystream index sequence check driving idx_err.
module zuc_ks_xor
    import zuc_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LEN_W      = ZUC_LEN_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_W-1:0]      len,
    input  logic [ZUC_WORD_W-1:0] ks_z,
    input  logic                  ks_done,
    input  logic [LEN_W-1:0]      ks_idx,
    input  logic [ZUC_WORD_W-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [ZUC_WORD_W-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  busy,
    output logic                  finished,
    output logic                  ovf,
    output logic                  idx_err
);

    zuc_state_e            state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      in_cnt_q, in_cnt_d;
    logic [LEN_W-1:0]      out_cnt_q, out_cnt_d;
    logic [ZUC_WORD_W-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  finished_q, finished_d;
    logic                  ovf_q, ovf_d;

    logic                  load_c;
    logic                  msg_start_c;
    logic                  fifo_push, fifo_pop, fifo_flush;
    logic                  fifo_empty, fifo_full;
    logic [ZUC_WORD_W-1:0] fifo_head;

    zuc_ks_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ZUC_WORD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (ks_z),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        in_cnt_d     = in_cnt_q;
        out_cnt_d    = out_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        finished_d   = 1'b0;
        ovf_d        = ovf_q;
        load_c       = 1'b0;
        msg_start_c  = 1'b0;
        fifo_push    = 1'b0;
        fifo_pop     = 1'b0;
        fifo_flush   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        msg_start_c = 1'b1;
                        state_d     = ST_RUN;
                        len_d       = len;
                        in_cnt_d    = '0;
                        out_cnt_d   = '0;
                        ovf_d       = 1'b0;
                        fifo_flush  = 1'b1;
                    end else begin
                        finished_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                fifo_push = ks_done;
                load_c    = !fifo_empty && din_valid && (in_cnt_q < len_q) &&
                            (!dout_valid_q || dout_ready);
                fifo_pop  = load_c;
                if (ks_done && fifo_full && !load_c) ovf_d = 1'b1;

                if (dout_valid_q && dout_ready) begin
                    dout_valid_d = 1'b0;
                    out_cnt_d    = out_cnt_q + LEN_W'(1);
                end
                if (load_c) begin
                    dout_d       = ks_xor(din, fifo_head);
                    dout_valid_d = 1'b1;
                    in_cnt_d     = in_cnt_q + LEN_W'(1);
                end
                // Last word gone downstream: surplus keystream is thrown away.
                if (dout_valid_q && dout_ready &&
                    (LEN_W'(out_cnt_q + LEN_W'(1)) == len_q)) begin
                    state_d      = ST_IDLE;
                    finished_d   = 1'b1;
                    fifo_flush   = 1'b1;
                    dout_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            finished_q   <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            finished_q   <= finished_d;
            ovf_q        <= ovf_d;
        end
    end

    assign din_ready  = load_c;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (state_q == ST_RUN);
    assign finished   = finished_q;
    assign ovf        = ovf_q;

`ifdef ZUC_IDX_CHECK_EN
    logic             idx_seen_q, idx_seen_d;
    logic [LEN_W-1:0] idx_last_q, idx_last_d;
    logic             idx_err_q, idx_err_d;

    // First strobe of a message sets the base; each later one must be previous + 1.
    always_comb begin
        idx_seen_d = idx_seen_q;
        idx_last_d = idx_last_q;
        idx_err_d  = idx_err_q;
        if (msg_start_c) begin
            idx_seen_d = 1'b0;
            idx_err_d  = 1'b0;
        end else if ((state_q == ST_RUN) && ks_done) begin
            idx_seen_d = 1'b1;
            idx_last_d = ks_idx;
            if (idx_seen_q && (ks_idx != LEN_W'(idx_last_q + LEN_W'(1)))) idx_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_seen_q <= 1'b0;
            idx_last_q <= '0;
            idx_err_q  <= 1'b0;
        end else begin
            idx_seen_q <= idx_seen_d;
            idx_last_q <= idx_last_d;
            idx_err_q  <= idx_err_d;
        end
    end

    assign idx_err = idx_err_q;
`else
    logic idx_unused;
    assign idx_unused = ^ks_idx;
    assign idx_err    = 1'b0;
`endif

endmodule

// File: tb/tb_zuc_ks_xor.sv
// Directed self-checking bench for zuc_ks_xor; the index-check scenario
// switches expectation with ZUC_IDX_CHECK_EN.
module tb_zuc_ks_xor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic [31:0] ks_z;
    logic        ks_done;
    logic [7:0]  ks_idx;
    logic [31:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        busy;
    logic        finished;
    logic        ovf;
    logic        idx_err;

    int          n_run  = 0;
    int          n_fail = 0;
    logic [7:0]  idx_n;
    logic [31:0] obs [64];
    int          n_obs;
    int          fin_seen;
    logic [31:0] exp_basic [4] = '{32'hEEEEEEEE, 32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB};

    zuc_ks_xor #(.FIFO_DEPTH(16), .LEN_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .ks_z       (ks_z),
        .ks_done    (ks_done),
        .ks_idx     (ks_idx),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .finished   (finished),
        .ovf        (ovf),
        .idx_err    (idx_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_msg(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        step();
        start = 1'b0;
        idx_n = 8'd0;
    endtask

    task automatic push_ks(input logic [31:0] z);
        ks_done = 1'b1;
        ks_z    = z;
        ks_idx  = idx_n;
        idx_n   = idx_n + 8'd1;
        step();
        ks_done = 1'b0;
    endtask

    // Drives a constant din until finished is seen, recording every accepted dout.
    task automatic drain(input logic [31:0] dw, input int max_cyc);
        din        = dw;
        din_valid  = 1'b1;
        dout_ready = 1'b1;
        n_obs      = 0;
        fin_seen   = 0;
        for (int c = 0; c < max_cyc; c++) begin
            #1;
            if (dout_valid && dout_ready && n_obs < 64) begin
                obs[n_obs] = dout;
                n_obs++;
            end
            step();
            if (finished) begin
                fin_seen++;
                break;
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; len = '0; ks_z = '0; ks_done = 1'b0; ks_idx = '0;
        din = '0; din_valid = 1'b0; dout_ready = 1'b0; idx_n = '0;
        #13;
        n_run++;
        if (dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout: got %h expected 00000000", dout); end
        n_run++;
        if ({dout_valid, din_ready, busy, finished, ovf, idx_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000", {dout_valid, din_ready, busy, finished, ovf, idx_err});
        end
        rst_n = 1'b1;
        step();
        n_run++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        int k = 0, got = 0, hs_c = -1, fin_c = -1, fin_n = 0;
        start_msg(8'd4);
        n_run++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
        din = 32'hFFFFFFFF; din_valid = 1'b1; dout_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (k < 4) begin
                ks_done = 1'b1; ks_z = 32'h11111111 * (k + 1); ks_idx = idx_n; idx_n = idx_n + 8'd1; k++;
            end else begin
                ks_done = 1'b0;
            end
            #1;
            if (c == 0) begin
                n_run++;
                if (din_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_empty: got %b expected 0", din_ready); end
            end
            if (c == 1) begin
                n_run++;
                if (din_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_load: got %b expected 1", din_ready); end
            end
            if (finished) begin fin_n++; fin_c = c; end
            if (dout_valid && dout_ready && got < 4) begin
                n_run++;
                if (dout !== exp_basic[got]) begin
                    n_fail++; $display("FAIL basic_dout%0d: got %h expected %h", got, dout, exp_basic[got]);
                end
                got++;
                if (got == 4) hs_c = c;
            end
            step();
        end
        ks_done = 1'b0; din_valid = 1'b0;
        n_run++;
        if (got !== 4) begin n_fail++; $display("FAIL basic_count: got %0d expected 4", got); end
        n_run++;
        if (fin_n !== 1 || fin_c !== hs_c + 1) begin
            n_fail++; $display("FAIL basic_finished: pulses %0d at cycle %0d, expected 1 at cycle %0d", fin_n, fin_c, hs_c + 1);
        end
        n_run++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got busy %b expected 0", busy); end
    endtask

    task automatic test_stall();
        int got = 0, stall = 0;
        logic [31:0] held = '0;
        start_msg(8'd6);
        for (int i = 0; i < 6; i++) push_ks(32'h12345600 + i);
        din = 32'hFF000000; din_valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            dout_ready = !(got == 2 && stall < 5);
            #1;
            if (dout_valid && !dout_ready) begin
                if (stall == 0) held = dout;
                else begin
                    n_run++;
                    if (dout !== held) begin n_fail++; $display("FAIL stall_hold: got %h expected %h", dout, held); end
                end
                n_run++;
                if (din_ready !== 1'b0) begin n_fail++; $display("FAIL stall_din_ready: got %b expected 0", din_ready); end
                stall++;
            end
            if (dout_valid && dout_ready) begin
                n_run++;
                if (dout !== 32'hED345600 + got) begin
                    n_fail++; $display("FAIL stall_dout%0d: got %h expected %h", got, dout, 32'hED345600 + got);
                end
                got++;
            end
            step();
            if (finished) break;
        end
        din_valid = 1'b0; dout_ready = 1'b1;
        n_run++;
        if (got !== 6 || stall !== 5) begin
            n_fail++; $display("FAIL stall_count: got %0d words %0d stalls expected 6 words 5 stalls", got, stall);
        end
    endtask

    task automatic test_overflow();
        start_msg(8'd16);
        for (int i = 0; i < 18; i++) begin
            push_ks(32'h10000000 + i);
            if (i == 15) begin
                n_run++;
                if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_at16: got %b expected 0", ovf); end
            end
            if (i == 16) begin
                n_run++;
                if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_at17: got %b expected 1", ovf); end
            end
        end
        drain(32'h0, 80);
        n_run++;
        if (n_obs !== 16 || fin_seen !== 1) begin
            n_fail++; $display("FAIL ovf_drain: got %0d words fin %0d expected 16 words fin 1", n_obs, fin_seen);
        end
        for (int i = 0; i < 16 && i < n_obs; i++) begin
            n_run++;
            if (obs[i] !== 32'h10000000 + i) begin
                n_fail++; $display("FAIL ovf_word%0d: got %h expected %h", i, obs[i], 32'h10000000 + i);
            end
        end
        n_run++;
        if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", ovf); end
    endtask

    task automatic test_len0_and_ignore();
        start_msg(8'd0);
        n_run++;
        if (finished !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL len0_pulse: got fin %b busy %b expected fin 1 busy 0", finished, busy);
        end
        step();
        n_run++;
        if (finished !== 1'b0) begin n_fail++; $display("FAIL len0_width: got %b expected 0", finished); end
        start_msg(8'd2);
        n_run++;
        if (busy !== 1'b1 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL restart_clear: got busy %b ovf %b expected busy 1 ovf 0", busy, ovf);
        end
        start = 1'b1; len = 8'd5;
        step();
        start = 1'b0;
        push_ks(32'hCAFEF00D);
        push_ks(32'h0BADBEEF);
        drain(32'h01010101, 40);
        n_run++;
        if (n_obs !== 2 || fin_seen !== 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL ignore_start: got %0d words fin %0d busy %b expected 2 words fin 1 busy 0", n_obs, fin_seen, busy);
        end
        n_run++;
        if (obs[0] !== 32'hCBFFF10C || obs[1] !== 32'h0AACBFEE) begin
            n_fail++; $display("FAIL ignore_data: got %h %h expected cbfff10c 0aacbfee", obs[0], obs[1]);
        end
    endtask

    task automatic test_reset_mid();
        int got = 0;
        start_msg(8'd8);
        for (int i = 0; i < 8; i++) push_ks(32'h77770000 + i);
        din = 32'h0; din_valid = 1'b1; dout_ready = 1'b1;
        for (int c = 0; c < 30 && got < 2; c++) begin
            #1;
            if (dout_valid && dout_ready) got++;
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_run++;
        if (got !== 2 || dout !== 32'h0) begin
            n_fail++; $display("FAIL midrst_dout: got %h after %0d words expected 00000000 after 2", dout, got);
        end
        n_run++;
        if ({dout_valid, din_ready, busy, finished, ovf, idx_err} !== 6'b0) begin
            n_fail++; $display("FAIL midrst_flags: got %b expected 000000", {dout_valid, din_ready, busy, finished, ovf, idx_err});
        end
        rst_n = 1'b1; din_valid = 1'b0;
        step();
        start_msg(8'd2);
        push_ks(32'h000000AA);
        push_ks(32'h000000BB);
        drain(32'h0000FF00, 40);
        n_run++;
        if (n_obs !== 2 || fin_seen !== 1 || obs[0] !== 32'h0000FFAA || obs[1] !== 32'h0000FFBB) begin
            n_fail++; $display("FAIL midrst_restart: got %0d words %h %h fin %0d expected 2 words 0000ffaa 0000ffbb fin 1",
                               n_obs, obs[0], obs[1], fin_seen);
        end
    endtask

    task automatic test_idx();
        logic exp_err;
`ifdef ZUC_IDX_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        start_msg(8'd4);
        push_ks(32'h1);
        push_ks(32'h2);
        n_run++;
        if (idx_err !== 1'b0) begin n_fail++; $display("FAIL idx_ok_seq: got %b expected 0", idx_err); end
        idx_n = 8'd3;
        push_ks(32'h3);
        n_run++;
        if (idx_err !== exp_err) begin n_fail++; $display("FAIL idx_skip: got %b expected %b", idx_err, exp_err); end
        push_ks(32'h4);
        drain(32'h0, 40);
        n_run++;
        if (idx_err !== exp_err || n_obs !== 4) begin
            n_fail++; $display("FAIL idx_sticky: got err %b words %0d expected err %b words 4", idx_err, n_obs, exp_err);
        end
        start_msg(8'd2);
        n_run++;
        if (idx_err !== 1'b0) begin n_fail++; $display("FAIL idx_clear: got %b expected 0", idx_err); end
        idx_n = 8'd255;
        push_ks(32'h5);
        push_ks(32'h6);
        n_run++;
        if (idx_err !== 1'b0) begin n_fail++; $display("FAIL idx_wrap: got %b expected 0", idx_err); end
        drain(32'h0, 40);
        n_run++;
        if (n_obs !== 2 || obs[0] !== 32'h5 || obs[1] !== 32'h6) begin
            n_fail++; $display("FAIL idx_data: got %0d words %h %h expected 2 words 00000005 00000006", n_obs, obs[0], obs[1]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_len0_and_ignore();
        test_reset_mid();
        test_idx();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
